// File: rtl/approx_mult_serial_core_if.sv
// Tile command port: 3-bit command with 8-bit data in, 8-bit readback and status flags out.
// There is no backpressure; the host pulses one command at a time, with NOP between commands.
interface approx_mult_serial_core_if;
  logic [2:0] comm;
  logic [7:0] in_8b;
  logic [7:0] out_8b;
  logic       busy;
  logic       done;

  modport master (output comm, in_8b, input  out_8b, busy, done);
  modport slave  (input  comm, in_8b, output out_8b, busy, done);
endinterface

// File: rtl/approx_mult_serial_core.sv
// Shift-add unsigned multiplier with runtime partial-product column truncation (K LSB columns dropped).
// Latency is WIDTH cycles from START to done. There is no backpressure: commands are edge-detected against the previous cycle's code.
module approx_mult_serial_core #(
  parameter int          WIDTH   = 16,
  parameter logic [3:0]  RESET_K = 4'd0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  approx_mult_serial_core_if.slave   tile
);

  localparam int PW     = 2 * WIDTH;
  localparam int NBYTES = PW / 8;
  localparam int PTR_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [2:0] {
    CMD_NOP    = 3'b000, CMD_LOAD_A = 3'b001, CMD_LOAD_B = 3'b010, CMD_START  = 3'b011,
    CMD_READ   = 3'b100, CMD_SET_K  = 3'b101, CMD_CLEAR  = 3'b110, CMD_STATUS = 3'b111
  } cmd_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [3:0]         k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               sel_q, sel_d;
  logic               err_q, err_d;
  logic [2:0]         comm_q, comm_d;

  logic               cmd_acc;
  logic               is_busy;
  logic [PW-1:0]      pp;

  assign cmd_acc = (tile.comm != CMD_NOP) && (comm_q == CMD_NOP);
  assign is_busy = (state_q == S_BUSY);
  // Zeroing the K low columns of each shifted row is the whole approximation.
  assign pp      = ({{WIDTH{1'b0}}, a_q} << cnt_q) & ({PW{1'b1}} << k_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    err_d   = err_q;
    comm_d  = tile.comm;

    if (is_busy) begin
      if (b_q[cnt_q]) acc_d = acc_q + pp;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_DONE;
    end

    if (cmd_acc) begin
      case (cmd_t'(tile.comm))
        CMD_LOAD_A: if (is_busy) err_d = 1'b1; else a_d = WIDTH'({a_q, tile.in_8b});
        CMD_LOAD_B: if (is_busy) err_d = 1'b1; else b_d = WIDTH'({b_q, tile.in_8b});
        CMD_SET_K:  if (is_busy) err_d = 1'b1; else k_d = tile.in_8b[3:0];
        CMD_START: begin
          if (is_busy) begin
            err_d = 1'b1;
          end else begin
            acc_d   = '0;
            cnt_d   = '0;
            ptr_d   = '0;
            sel_d   = 1'b0;
            state_d = S_BUSY;
          end
        end
        CMD_READ: begin
          ptr_d = (ptr_q == PTR_W'(NBYTES - 1)) ? '0 : ptr_q + PTR_W'(1);
          sel_d = 1'b0;
        end
        CMD_CLEAR: begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ptr_d   = '0;
          sel_d   = 1'b0;
          err_d   = 1'b0;
        end
        CMD_STATUS: sel_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= RESET_K;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      comm_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      comm_q  <= comm_d;
    end
  end

  assign tile.busy   = is_busy;
  assign tile.done   = (state_q == S_DONE);
  assign tile.out_8b = sel_q ? {is_busy, (state_q == S_DONE), err_q, 1'b0, k_q}
                             : acc_q[8*ptr_q +: 8];

endmodule

// File: tb/tb_approx_mult_serial_core.sv
// Directed bench for the 16-bit approximate multiplier: exact and truncated products, handshake,
// busy protection, abort, async reset and a random sweep against the sum-of-truncated-rows formula.
module tb_approx_mult_serial_core;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  approx_mult_serial_core_if tile();

  approx_mult_serial_core #(.WIDTH(16), .RESET_K(4'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tile  (tile)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] C_LDA = 3'b001, C_LDB = 3'b010, C_START = 3'b011, C_READ = 3'b100,
                         C_SETK = 3'b101, C_CLEAR = 3'b110, C_STAT = 3'b111;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One command pulse followed by a NOP cycle; returns on the negedge after acceptance.
  task automatic cmd(input logic [2:0] c, input logic [7:0] d);
    @(negedge clk);
    tile.comm  = c;
    tile.in_8b = d;
    @(negedge clk);
    tile.comm  = 3'b000;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [3:0] k);
    cmd(C_LDA, a[15:8]);
    cmd(C_LDA, a[7:0]);
    cmd(C_LDB, b[15:8]);
    cmd(C_LDB, b[7:0]);
    cmd(C_SETK, {4'hA, k});
  endtask

  task automatic run_op(input string tag);
    int n;
    cmd(C_START, 8'h00);
    n = 0;
    while (!tile.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'd0, tile.done}, 32'd1);
  endtask

  task automatic read_prod(output logic [31:0] p);
    for (int i = 0; i < 4; i++) begin
      p[8*i +: 8] = tile.out_8b;
      cmd(C_READ, 8'h00);
    end
  endtask

  function automatic logic [31:0] gold(input logic [15:0] a, input logic [15:0] b, input logic [3:0] k);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 16; i++)
      if (b[i]) s += ({16'h0, a} << i) & (32'hFFFF_FFFF << k);
    return s;
  endfunction

  typedef struct { logic [15:0] a; logic [15:0] b; logic [3:0] k; logic [31:0] p; } vec_t;
  vec_t vecs [5];

  logic [31:0] prod;
  logic [15:0] ra, rb;
  logic [3:0]  rk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'hFFFF, 16'hFFFF, 4'd0,  32'hFFFE_0001};
    vecs[1] = '{16'h0001, 16'h8000, 4'd15, 32'h0000_8000};
    vecs[2] = '{16'h0001, 16'h4000, 4'd15, 32'h0000_0000};
    vecs[3] = '{16'h00FF, 16'h0101, 4'd4,  32'h0000_FFF0};
    vecs[4] = '{16'h8000, 16'h8000, 4'd0,  32'h4000_0000};

    tile.comm  = 3'b000;
    tile.in_8b = 8'h00;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out",  {24'd0, tile.out_8b}, 32'h00);
    chk("rst_busy", {31'd0, tile.busy},   32'd0);
    chk("rst_done", {31'd0, tile.done},   32'd0);
    rst_n = 1'b1;
    cmd(C_STAT, 8'h00);
    chk("rst_status", {24'd0, tile.out_8b}, 32'h00);

    // Exact product with cycle-accurate latency and byte walk.
    load(16'h1234, 16'h5678, 4'd0);
    cmd(C_START, 8'h00);
    chk("ex_busy_t0", {31'd0, tile.busy}, 32'd1);
    chk("ex_done_t0", {31'd0, tile.done}, 32'd0);
    repeat (15) @(negedge clk);
    chk("ex_done_t15", {31'd0, tile.done}, 32'd0);
    @(negedge clk);
    chk("ex_done_t16", {31'd0, tile.done}, 32'd1);
    chk("ex_busy_t16", {31'd0, tile.busy}, 32'd0);
    chk("ex_byte0", {24'd0, tile.out_8b}, 32'h60);
    cmd(C_READ, 8'h00);
    chk("ex_byte1", {24'd0, tile.out_8b}, 32'h00);
    cmd(C_READ, 8'h00);
    chk("ex_byte2", {24'd0, tile.out_8b}, 32'h26);
    cmd(C_READ, 8'h00);
    chk("ex_byte3", {24'd0, tile.out_8b}, 32'h06);
    cmd(C_READ, 8'h00);
    chk("ex_wrap", {24'd0, tile.out_8b}, 32'h60);

    // Truncated K=8; upper nibble of SET_K data must be ignored.
    load(16'hFFFF, 16'hFFFF, 4'd8);
    run_op("tr");
    read_prod(prod);
    chk("tr_prod", prod, 32'hFFFD_F900);
    cmd(C_STAT, 8'h00);
    chk("tr_status", {24'd0, tile.out_8b}, 32'h48);

    // Held command code executes once.
    @(negedge clk);
    tile.comm = C_LDA; tile.in_8b = 8'hAB;
    repeat (10) @(negedge clk);
    tile.comm = 3'b000;
    @(negedge clk);
    tile.comm = C_LDA; tile.in_8b = 8'hCD;
    @(negedge clk);
    tile.comm = 3'b000;
    cmd(C_LDB, 8'h00);
    cmd(C_LDB, 8'h01);
    cmd(C_SETK, 8'h00);
    run_op("hs");
    read_prod(prod);
    chk("hs_a", prod, 32'h0000_ABCD);

    foreach (vecs[i]) begin
      load(vecs[i].a, vecs[i].b, vecs[i].k);
      run_op($sformatf("dir%0d", i));
      read_prod(prod);
      chk($sformatf("dir%0d_prod", i), prod, vecs[i].p);
    end

    // Writes during BUSY are dropped and flagged.
    load(16'h1234, 16'h5678, 4'd0);
    cmd(C_START, 8'h00);
    repeat (3) @(negedge clk);
    cmd(C_LDA, 8'hEE);
    cmd(C_SETK, 8'h03);
    cmd(C_STAT, 8'h00);
    chk("bp_status_mid", {24'd0, tile.out_8b}, 32'hA0);
    repeat (7) @(negedge clk);
    chk("bp_done", {31'd0, tile.done}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cmd(C_READ, 8'h00);
      prod[8*(i % 4) +: 8] = tile.out_8b;
    end
    chk("bp_prod", prod, 32'h0626_0060);
    cmd(C_STAT, 8'h00);
    chk("bp_status_end", {24'd0, tile.out_8b}, 32'h60);

    // CLEAR aborts mid-operation; operands survive.
    cmd(C_START, 8'h00);
    repeat (5) @(negedge clk);
    cmd(C_CLEAR, 8'h00);
    chk("ab_busy", {31'd0, tile.busy},   32'd0);
    chk("ab_done", {31'd0, tile.done},   32'd0);
    chk("ab_out",  {24'd0, tile.out_8b}, 32'h00);
    cmd(C_STAT, 8'h00);
    chk("ab_status", {24'd0, tile.out_8b}, 32'h00);
    run_op("ab_rerun");
    read_prod(prod);
    chk("ab_prod", prod, 32'h0626_0060);

    // Restart from DONE without CLEAR.
    for (int it = 0; it < 150; it++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rk = 4'($urandom_range(0, 15));
      load(ra, rb, rk);
      run_op($sformatf("rnd%0d", it));
      read_prod(prod);
      chk($sformatf("rnd%0d_prod", it), prod, gold(ra, rb, rk));
    end

    // Async reset mid-BUSY restores reset values, including K and operands.
    load(16'h1234, 16'h5678, 4'd5);
    cmd(C_START, 8'h00);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs_busy", {31'd0, tile.busy},   32'd0);
    chk("rs_done", {31'd0, tile.done},   32'd0);
    chk("rs_out",  {24'd0, tile.out_8b}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cmd(C_STAT, 8'h00);
    chk("rs_status", {24'd0, tile.out_8b}, 32'h00);
    cmd(C_LDB, 8'hFF);
    cmd(C_LDB, 8'hFF);
    run_op("rs_rerun");
    read_prod(prod);
    chk("rs_prod_a0", prod, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
